// File: rtl/imem_load_controller.sv
// ----------------------------------------------------------------------------
// imem_load_controller
//
// Boot-time sequencer that owns the instruction memory port. After reset it
// takes a byte stream from the UART receiver: a 4-byte little-endian word
// count followed by that many little-endian 32-bit words. The words are
// written to instruction memory from byte address 0 upward. When the load
// completes, the memory read address is handed to the fetch-stage PC and
// cpu_run releases the pipeline.
//
// Optional build macro: IMEM_LOAD_CHECKSUM_EN
//   When defined, one trailing byte follows the data and must equal the XOR
//   of every length and data byte. A match lets the CPU run; a mismatch
//   latches load_error. Without the macro, no trailing byte is consumed.
//
// Parameters
//   MEM_WORDS    instruction memory depth in 32-bit words (larger loads rejected)
//   ADDR_W       width of the byte address driven to instruction memory
//
// Ports
//   clk          clock
//   rst          synchronous, active-high reset
//   rx_data      byte from the UART receiver
//   rx_valid     rx_data valid
//   rx_ready     controller can accept a byte
//   fetch_addr   PC from the fetch stage
//   imem_addr    byte address to instruction memory
//   imem_we      instruction memory write enable (one-cycle pulse per word)
//   imem_wdata   instruction memory write data
//   cpu_run      pipeline may fetch/execute
//   load_error   load rejected; sticky until reset
//   words_loaded count of words written so far
//
// state  | meaning
// -------+---------------------------------------------------------------
// LEN    | collecting the 4 length bytes
// DATA   | collecting data words, writing each one the cycle after its 4th byte
// CHK    | waiting for the checksum byte (checksum build only)
// RUN    | load complete; fetch owns imem_addr, cpu_run high (terminal)
// ERROR  | load rejected; load_error high, nothing accepted (terminal)
// ----------------------------------------------------------------------------
module imem_load_controller #(
   parameter int MEM_WORDS = 1024,
   parameter int ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              imem_we,
   output logic [31:0]       imem_wdata,
   output logic              cpu_run,
   output logic              load_error,
   output logic [ADDR_W-1:0] words_loaded
);

`ifdef IMEM_LOAD_CHECKSUM_EN
   typedef enum logic [2:0] {
      S_LEN   = 3'd0,
      S_DATA  = 3'd1,
      S_CHK   = 3'd2,
      S_RUN   = 3'd3,
      S_ERROR = 3'd4
   } state_t;
   localparam state_t S_FINAL = S_CHK;
`else
   typedef enum logic [2:0] {
      S_LEN   = 3'd0,
      S_DATA  = 3'd1,
      S_RUN   = 3'd3,
      S_ERROR = 3'd4
   } state_t;
   localparam state_t S_FINAL = S_RUN;
`endif

   state_t            state;
   state_t            state_nxt;

   logic [1:0]        byte_cnt;
   logic [23:0]       shreg;
   logic [31:0]       len_q;
   logic              last_q;
   logic [ADDR_W-1:0] wr_addr;
`ifdef IMEM_LOAD_CHECKSUM_EN
   logic [7:0]        csum_q;
`endif

   logic              accept;
   logic [31:0]       assembled;
   logic              len_done;
   logic              word_done;
   logic              last_word;
   logic              rdy_nxt;

   assign accept    = rx_valid && rx_ready;
   // Bytes arrive LSB first, so the newest byte lands on top of the three
   // already shifted in.
   assign assembled = {rx_data, shreg};
   assign len_done  = (state == S_LEN)  && accept && (byte_cnt == 2'd3);
   assign word_done = (state == S_DATA) && accept && (byte_cnt == 2'd3);
   assign last_word = word_done && ((32'(words_loaded) + 32'd1) == len_q);

   // Fetch owns the read address only once the load is finished.
   assign imem_addr = (state == S_RUN) ? fetch_addr : wr_addr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_LEN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      rdy_nxt   = 1'b0;
      case (state)
         S_LEN: begin
            if (len_done) begin
               if (assembled == 32'd0) begin
                  state_nxt = S_FINAL;
               end else if (assembled > 32'(MEM_WORDS)) begin
                  state_nxt = S_ERROR;
               end else begin
                  state_nxt = S_DATA;
               end
            end
         end
         S_DATA: begin
            // Leave only after the last word's write cycle so the write
            // address is still on imem_addr while imem_we is high.
            if (imem_we && last_q) begin
               state_nxt = S_FINAL;
            end
         end
`ifdef IMEM_LOAD_CHECKSUM_EN
         S_CHK: begin
            if (accept) begin
               state_nxt = (rx_data == csum_q) ? S_RUN : S_ERROR;
            end
         end
`endif
         S_RUN:   state_nxt = S_RUN;
         S_ERROR: state_nxt = S_ERROR;
         default: state_nxt = S_LEN;
      endcase

`ifdef IMEM_LOAD_CHECKSUM_EN
      rdy_nxt = (state_nxt == S_LEN) || (state_nxt == S_DATA) || (state_nxt == S_CHK);
`else
      rdy_nxt = (state_nxt == S_LEN) || (state_nxt == S_DATA);
`endif
      // Stop taking bytes during the final write cycle: anything after the
      // last data byte belongs to the checksum (or is not consumed at all).
      if (last_word) begin
         rdy_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt     <= 2'd0;
         shreg        <= 24'd0;
         len_q        <= 32'd0;
         last_q       <= 1'b0;
         wr_addr      <= '0;
         words_loaded <= '0;
         imem_we      <= 1'b0;
         imem_wdata   <= 32'd0;
         rx_ready     <= 1'b0;
         cpu_run      <= 1'b0;
         load_error   <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
         csum_q       <= 8'd0;
`endif
      end else begin
         imem_we    <= 1'b0;
         last_q     <= last_word;
         rx_ready   <= rdy_nxt;
         cpu_run    <= (state_nxt == S_RUN);
         load_error <= (state_nxt == S_ERROR);

         if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            shreg    <= assembled[31:8];
         end

`ifdef IMEM_LOAD_CHECKSUM_EN
         if (accept && ((state == S_LEN) || (state == S_DATA))) begin
            csum_q <= csum_q ^ rx_data;
         end
`endif

         if (len_done) begin
            len_q <= assembled;
         end

         if (word_done) begin
            imem_we      <= 1'b1;
            imem_wdata   <= assembled;
            wr_addr      <= words_loaded << 2;
            words_loaded <= words_loaded + ADDR_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_imem_load_controller.sv
// ----------------------------------------------------------------------------
// Testbench for imem_load_controller: table of complete load streams applied
// after a reset each, plus hand-written sequences for reset state, reset in
// the middle of a word, a full-depth load, and bytes offered while not ready.
// Build with +define+IMEM_LOAD_CHECKSUM_EN to exercise the checksum variant.
// ----------------------------------------------------------------------------
module tb_imem_load_controller;

   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic [AW-1:0] fetch_addr;
   logic [AW-1:0] imem_addr;
   logic          imem_we;
   logic [31:0]   imem_wdata;
   logic          cpu_run;
   logic          load_error;
   logic [AW-1:0] words_loaded;

   imem_load_controller #(.MEM_WORDS(1024), .ADDR_W(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .fetch_addr   (fetch_addr),
      .imem_addr    (imem_addr),
      .imem_we      (imem_we),
      .imem_wdata   (imem_wdata),
      .cpu_run      (cpu_run),
      .load_error   (load_error),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Write log: every imem_we pulse seen, in order.
   int          wr_n = 0;
   logic [31:0] wa [0:4095];
   logic [31:0] wd [0:4095];
   logic [31:0] last_a, last_d;

   always @(negedge clk) begin
      if (imem_we) begin
         if (wr_n < 4096) begin
            wa[wr_n] = imem_addr;
            wd[wr_n] = imem_wdata;
         end
         last_a = imem_addr;
         last_d = imem_wdata;
         wr_n   = wr_n + 1;
      end
   end

   int base;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Called at a negedge; returns at a negedge with rx_valid low.
   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      while (!rx_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!rx_ready) chk("rx_ready timeout", {31'd0, rx_ready}, 32'd1);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'd0;
      repeat (2) @(negedge clk);
      rst  = 1'b0;
      base = wr_n;
   endtask

   typedef struct packed {
      logic [127:0] s;     // stream, first byte sent in the top 8 bits
      logic [7:0]   nb;    // bytes to send
      logic [7:0]   gap;   // idle cycles after each byte
      logic [7:0]   nw;    // expected write count
      logic [31:0]  a0;
      logic [31:0]  d0;
      logic [31:0]  a1;
      logic [31:0]  d1;
      logic [31:0]  la;    // expected held imem_addr outside RUN
      logic [31:0]  wl;
      logic         run;
      logic         err;
   } tv_t;

   tv_t tv [8];
   int  nv;

   initial begin
      logic [127:0] sv;
      logic [31:0]  ea;

      // 2 words, back to back
`ifdef IMEM_LOAD_CHECKSUM_EN
      tv[0] = '{128'h02000000_13000000_93001000_92000000, 8'd13, 8'd0, 8'd2,
                32'h0, 32'h00000013, 32'h4, 32'h00100093, 32'h4, 32'd2, 1'b1, 1'b0};
      tv[1] = '{128'h0, 8'd5, 8'd0, 8'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'd0, 1'b1, 1'b0};
      tv[3] = '{128'h01000000_EFBEADDE_23000000_00000000, 8'd9, 8'd4, 8'd1,
                32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'd1, 1'b1, 1'b0};
      tv[5] = '{128'h01000000_13000000_12000000_00000000, 8'd9, 8'd0, 8'd1,
                32'h0, 32'h00000013, 32'h0, 32'h0, 32'h0, 32'd1, 1'b1, 1'b0};
      tv[6] = '{128'h01000000_13000000_00000000_00000000, 8'd9, 8'd0, 8'd1,
                32'h0, 32'h00000013, 32'h0, 32'h0, 32'h0, 32'd1, 1'b0, 1'b1};
      nv = 7;
`else
      tv[0] = '{128'h02000000_13000000_93001000_00000000, 8'd12, 8'd0, 8'd2,
                32'h0, 32'h00000013, 32'h4, 32'h00100093, 32'h4, 32'd2, 1'b1, 1'b0};
      tv[1] = '{128'h0, 8'd4, 8'd0, 8'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'd0, 1'b1, 1'b0};
      tv[3] = '{128'h01000000_EFBEADDE_00000000_00000000, 8'd8, 8'd4, 8'd1,
                32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'd1, 1'b1, 1'b0};
      nv = 5;
`endif
      // len = 1025: one past the memory depth
      tv[2] = '{128'h01040000_00000000_00000000_00000000, 8'd4, 8'd0, 8'd0,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'd0, 1'b0, 1'b1};
      // len = 0x01000000: only the top length byte is non-zero
      tv[4] = '{128'h00000001_00000000_00000000_00000000, 8'd4, 8'd0, 8'd0,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'd0, 1'b0, 1'b1};

      // ---- reset state ----
      rst        = 1'b1;
      rx_valid   = 1'b0;
      rx_data    = 8'd0;
      fetch_addr = 32'h0;
      repeat (3) @(negedge clk);
      chk("reset rx_ready",     {31'd0, rx_ready},   32'd0);
      chk("reset imem_we",      {31'd0, imem_we},    32'd0);
      chk("reset imem_wdata",   imem_wdata,          32'd0);
      chk("reset cpu_run",      {31'd0, cpu_run},    32'd0);
      chk("reset load_error",   {31'd0, load_error}, 32'd0);
      chk("reset words_loaded", words_loaded,        32'd0);
      chk("reset imem_addr",    imem_addr,           32'd0);
      rst  = 1'b0;
      base = wr_n;

      // ---- table ----
      for (int i = 0; i < nv; i++) begin
         do_reset();
         fetch_addr = 32'h100 + 32'(i * 8);
         sv = tv[i].s;
         for (int k = 0; k < int'(tv[i].nb); k++) begin
            send_byte(sv[127 - 8*k -: 8]);
            repeat (int'(tv[i].gap)) @(negedge clk);
         end
         repeat (6) @(negedge clk);
         chk($sformatf("v%0d writes", i), 32'(wr_n - base), 32'(tv[i].nw));
         if (tv[i].nw >= 8'd1) begin
            chk($sformatf("v%0d addr0", i), wa[base], tv[i].a0);
            chk($sformatf("v%0d data0", i), wd[base], tv[i].d0);
         end
         if (tv[i].nw >= 8'd2) begin
            chk($sformatf("v%0d addr1", i), wa[base+1], tv[i].a1);
            chk($sformatf("v%0d data1", i), wd[base+1], tv[i].d1);
         end
         chk($sformatf("v%0d words_loaded", i), words_loaded, tv[i].wl);
         chk($sformatf("v%0d cpu_run", i), {31'd0, cpu_run}, {31'd0, tv[i].run});
         chk($sformatf("v%0d load_error", i), {31'd0, load_error}, {31'd0, tv[i].err});
         chk($sformatf("v%0d rx_ready", i), {31'd0, rx_ready}, 32'd0);
         ea = tv[i].run ? fetch_addr : tv[i].la;
         chk($sformatf("v%0d imem_addr", i), imem_addr, ea);
      end

      // ---- reset after 2 of 4 data bytes, then a fresh len = 1 load ----
      do_reset();
      send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h13); send_byte(8'h00);
      do_reset();
      repeat (3) @(negedge clk);
      chk("midrst writes",       32'(wr_n - base), 32'd0);
      chk("midrst words_loaded", words_loaded,     32'd0);
      send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h37); send_byte(8'h12); send_byte(8'h00); send_byte(8'h00);
`ifdef IMEM_LOAD_CHECKSUM_EN
      send_byte(8'h24);
`endif
      repeat (6) @(negedge clk);
      chk("reload writes",  32'(wr_n - base), 32'd1);
      chk("reload addr",    wa[base],         32'h0);
      chk("reload data",    wd[base],         32'h00001237);
      chk("reload cpu_run", {31'd0, cpu_run}, 32'd1);

      // ---- bytes offered in RUN are never taken; fetch passthrough ----
      do_reset();
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
`ifdef IMEM_LOAD_CHECKSUM_EN
      send_byte(8'h00);
`endif
      rx_data  = 8'hAA;
      rx_valid = 1'b1;
      repeat (6) @(negedge clk);
      rx_valid = 1'b0;
      chk("hold writes",       32'(wr_n - base),    32'd0);
      chk("hold words_loaded", words_loaded,        32'd0);
      chk("hold cpu_run",      {31'd0, cpu_run},    32'd1);
      chk("hold load_error",   {31'd0, load_error}, 32'd0);
      fetch_addr = 32'hDEADBEE0;
      #1;
      chk("fetch passthrough a", imem_addr, 32'hDEADBEE0);
      fetch_addr = 32'h00000008;
      #1;
      chk("fetch passthrough b", imem_addr, 32'h00000008);

      // ---- full-depth load: len = MEM_WORDS ----
      do_reset();
      send_byte(8'h00); send_byte(8'h04); send_byte(8'h00); send_byte(8'h00);
      for (int k = 0; k < 4096; k++) send_byte(8'(k));
`ifdef IMEM_LOAD_CHECKSUM_EN
      send_byte(8'h04);
`endif
      repeat (6) @(negedge clk);
      chk("full writes",       32'(wr_n - base), 32'd1024);
      chk("full addr1",        wa[base+1],       32'h4);
      chk("full data1",        wd[base+1],       32'h07060504);
      chk("full last addr",    last_a,           32'hFFC);
      chk("full last data",    last_d,           32'hFFFEFDFC);
      chk("full words_loaded", words_loaded,     32'd1024);
      chk("full cpu_run",      {31'd0, cpu_run}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule
